// File: rtl/lab_readout_sched.sv
// Trigger-driven readout sequencer for NUM_LABS LAB controllers feeding a four-deep
// event buffer ring; one LAB is read at a time while hold_o freezes sampling.
module lab_readout_sched #(
  parameter int unsigned NUM_LABS   = 4,
  parameter int unsigned HOLD_DELAY = 8,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                trig_i,
  input  logic [NUM_LABS-1:0] lab_enable_i,
  input  logic [NUM_LABS-1:0] done_i,
  input  logic                rd_ack_i,
  output logic                hold_o,
  output logic [NUM_LABS-1:0] readout_o,
  output logic [1:0]          wr_buf_o,
  output logic [1:0]          rd_buf_o,
  output logic [2:0]          occupancy_o,
  output logic                event_done_o,
  output logic [NUM_LABS-1:0] timeout_o,
  output logic [7:0]          dropped_cnt_o
);

  localparam int unsigned IdxW = (NUM_LABS > 1) ? $clog2(NUM_LABS) : 1;
  localparam int unsigned DlyW = (HOLD_DELAY > 1) ? $clog2(HOLD_DELAY) : 1;
  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_LABS - 1);
  localparam logic [DlyW-1:0] DlyLast = DlyW'(HOLD_DELAY - 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHoldWait,
    StSelect,
    StReadWait,
    StFinish
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [NUM_LABS-1:0] mask_q, mask_d;
  logic [DlyW-1:0]     dly_q, dly_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic                hold_q, hold_d;
  logic [NUM_LABS-1:0] readout_q, readout_d;
  logic                event_done_q, event_done_d;
  logic [1:0]          wr_ptr_q, wr_ptr_d;
  logic [1:0]          rd_ptr_q, rd_ptr_d;
  logic [2:0]          occ_q, occ_d;
  logic [NUM_LABS-1:0] timeout_q, timeout_d;
  logic [7:0]          dropped_q, dropped_d;
  logic                advance;
  logic                commit;
  logic                ack_ok;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mask_d       = mask_q;
    dly_d        = dly_q;
    tmr_d        = tmr_q;
    hold_d       = hold_q;
    readout_d    = '0;
    event_done_d = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    timeout_d    = timeout_q;
    dropped_d    = dropped_q;
    advance      = 1'b0;
    commit       = 1'b0;

    unique case (state_q)
      StIdle: begin
        hold_d = 1'b0;
        if (trig_i) begin
          if (occ_q != 3'd4) begin
            mask_d  = lab_enable_i;
            idx_d   = '0;
            dly_d   = '0;
            hold_d  = 1'b1;
            state_d = StHoldWait;
          end else if (dropped_q != 8'hff) begin
            dropped_d = dropped_q + 8'd1;
          end
        end
      end
      StHoldWait: begin
        if (dly_q == DlyLast) begin
          state_d = StSelect;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      StSelect: begin
        if (mask_q[idx_q]) begin
          for (int i = 0; i < NUM_LABS; i++) begin
            readout_d[i] = (idx_q == IdxW'(i));
          end
          tmr_d   = '0;
          state_d = StReadWait;
        end else begin
          advance = 1'b1;
        end
      end
      StReadWait: begin
        // A done on the final timer cycle takes priority over the timeout flag.
        if (done_i[idx_q]) begin
          advance = 1'b1;
        end else if (tmr_q == TmrLast) begin
          timeout_d[idx_q] = 1'b1;
          advance          = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StFinish: begin
        commit   = 1'b1;
        hold_d   = 1'b0;
        wr_ptr_d = wr_ptr_q + 2'd1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (idx_q == LastIdx) begin
        state_d      = StFinish;
        event_done_d = 1'b1;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = StSelect;
      end
    end

    ack_ok   = rd_ack_i && (occ_q != 3'd0);
    rd_ptr_d = ack_ok ? rd_ptr_q + 2'd1 : rd_ptr_q;
    occ_d    = occ_q + {2'b00, commit} - {2'b00, ack_ok};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      mask_q       <= '0;
      dly_q        <= '0;
      tmr_q        <= '0;
      hold_q       <= 1'b0;
      readout_q    <= '0;
      event_done_q <= 1'b0;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      occ_q        <= 3'd0;
      timeout_q    <= '0;
      dropped_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mask_q       <= mask_d;
      dly_q        <= dly_d;
      tmr_q        <= tmr_d;
      hold_q       <= hold_d;
      readout_q    <= readout_d;
      event_done_q <= event_done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      timeout_q    <= timeout_d;
      dropped_q    <= dropped_d;
    end
  end

  assign hold_o        = hold_q;
  assign readout_o     = readout_q;
  assign wr_buf_o      = wr_ptr_q;
  assign rd_buf_o      = rd_ptr_q;
  assign occupancy_o   = occ_q;
  assign event_done_o  = event_done_q;
  assign timeout_o     = timeout_q;
  assign dropped_cnt_o = dropped_q;

endmodule

// File: tb/tb_lab_readout_sched.sv
// Bench for lab_readout_sched: directed vector table, randomized events scored against
// a timeline model, plus drop-saturation and mid-event reset sequences.
module tb_lab_readout_sched;

  localparam int N  = 4;
  localparam int HD = 8;
  localparam int TO = 4096;

  logic         clk_i, rst_i, trig_i, rd_ack_i;
  logic [N-1:0] lab_enable_i, done_i;
  logic         hold_o, event_done_o;
  logic [N-1:0] readout_o, timeout_o;
  logic [1:0]   wr_buf_o, rd_buf_o;
  logic [2:0]   occupancy_o;
  logic [7:0]   dropped_cnt_o;

  lab_readout_sched #(
    .NUM_LABS  (N),
    .HOLD_DELAY(HD),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .trig_i       (trig_i),
    .lab_enable_i (lab_enable_i),
    .done_i       (done_i),
    .rd_ack_i     (rd_ack_i),
    .hold_o       (hold_o),
    .readout_o    (readout_o),
    .wr_buf_o     (wr_buf_o),
    .rd_buf_o     (rd_buf_o),
    .occupancy_o  (occupancy_o),
    .event_done_o (event_done_o),
    .timeout_o    (timeout_o),
    .dropped_cnt_o(dropped_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_vec = 0;
  int n_err = 0;

  // Per-LAB done latency in cycles after readout_o rises; negative means never.
  int lab_lat [N];

  // Reference model state.
  int         exp_occ, exp_wr, exp_rd, exp_drop;
  logic [3:0] exp_to_acc;
  int         plan_ro [N];
  int         plan_fin;
  logic [3:0] plan_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Timeline of one event, edges counted from the edge that samples the trigger.
  task automatic make_plan(input logic [3:0] mask);
    int t;
    t       = HD;
    plan_to = '0;
    for (int i = 0; i < N; i++) begin
      plan_ro[i] = -1;
      if (mask[i]) begin
        plan_ro[i] = t + 1;
        if (lab_lat[i] >= 0 && lab_lat[i] < TO) begin
          t = t + 2 + lab_lat[i];
        end else begin
          t = t + 1 + TO;
          plan_to[i] = 1'b1;
        end
      end else begin
        t = t + 1;
      end
    end
    plan_fin = t;
  endtask

  // Emulated LAB controllers answering readout_o with done_i.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      for (int i = 0; i < N; i++) begin
        automatic int j = i;
        automatic int d = lab_lat[i];
        if (readout_o[j] && d >= 0) begin
          fork
            begin
              repeat (d) @(posedge clk_i);
              #1 done_i[j] = 1'b1;
              @(posedge clk_i);
              #1 done_i[j] = 1'b0;
            end
          join_none
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_hold"}, hold_o, 0);
    check({tag, "_readout"}, readout_o, 0);
    check({tag, "_evdone"}, event_done_o, 0);
    check({tag, "_wr"}, wr_buf_o, 0);
    check({tag, "_rd"}, rd_buf_o, 0);
    check({tag, "_occ"}, occupancy_o, 0);
    check({tag, "_timeout"}, timeout_o, 0);
    check({tag, "_dropped"}, dropped_cnt_o, 0);
  endtask

  task automatic do_ack();
    rd_ack_i = 1'b1;
    @(posedge clk_i);
    #1 rd_ack_i = 1'b0;
    if (exp_occ > 0) begin
      exp_occ--;
      exp_rd = (exp_rd + 1) % 4;
    end
    check("ack_occ", occupancy_o, exp_occ);
    check("ack_rd", rd_buf_o, exp_rd);
    check("ack_wr", wr_buf_o, exp_wr);
  endtask

  task automatic do_drop();
    trig_i       = 1'b1;
    lab_enable_i = 4'hf;
    @(posedge clk_i);
    #1 trig_i = 1'b0;
    if (exp_drop < 255) exp_drop++;
    check("drop_hold", hold_o, 0);
    check("drop_cnt", dropped_cnt_o, exp_drop);
    check("drop_occ", occupancy_o, exp_occ);
    @(posedge clk_i);
    #1 check("drop_hold_next", hold_o, 0);
  endtask

  // Runs one accepted event, checking every cycle against the planned timeline.
  task automatic run_event(input logic [3:0] mask, input int exp_fin, input logic [3:0] exp_to,
                           input int stray, input bit ack_fin, input bit rand_trig);
    logic [3:0] exp_ro;
    int         wr0;
    bit         ack_ok;
    make_plan(mask);
    wr0 = exp_wr;
    check("idle_hold", hold_o, 0);
    trig_i       = 1'b1;
    lab_enable_i = mask;
    for (int rel = 0; rel <= exp_fin + 1; rel++) begin
      @(posedge clk_i);
      #1;
      exp_ro = '0;
      for (int i = 0; i < N; i++) if (mask[i] && plan_ro[i] == rel) exp_ro[i] = 1'b1;
      check("hold", hold_o, (rel <= exp_fin) ? 1 : 0);
      check("readout", readout_o, exp_ro);
      check("event_done", event_done_o, (rel == exp_fin) ? 1 : 0);
      check("wr_buf", wr_buf_o, (rel <= exp_fin) ? wr0 : (wr0 + 1) % 4);
      if (rel == 0) lab_enable_i = 4'($urandom);
      trig_i = (rand_trig && rel >= 1 && rel <= exp_fin && $urandom_range(0, 7) == 0);
      if (stray > 0 && rel == plan_ro[0] + 1) done_i[stray] = 1'b1;
      if (stray > 0 && rel == plan_ro[0] + 2) done_i[stray] = 1'b0;
      rd_ack_i = ack_fin && rel == exp_fin;
    end
    ack_ok  = ack_fin && exp_occ > 0;
    exp_occ = exp_occ + 1 - (ack_ok ? 1 : 0);
    if (ack_ok) exp_rd = (exp_rd + 1) % 4;
    exp_wr     = (exp_wr + 1) % 4;
    exp_to_acc = exp_to_acc | exp_to;
    check("occupancy", occupancy_o, exp_occ);
    check("rd_buf", rd_buf_o, exp_rd);
    check("timeout", timeout_o, exp_to_acc);
    check("dropped", dropped_cnt_o, exp_drop);
  endtask

  typedef struct packed {
    logic [3:0] mask;
    int         lat0, lat1, lat2, lat3;
    int         stray;
    logic       pre_drop;
    int         pre_acks;
    logic       ack_fin;
    int         exp_fin;
    logic [3:0] exp_to;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int  found;
    int  timeouts_left;
    logic [3:0] m;
    int  stray;

    tbl[0] = '{4'hf, 20, 20, 20, 20, -1, 1'b0, 0, 1'b0, 96, 4'h0};
    tbl[1] = '{4'h5, 20, -1, 20, -1, 1, 1'b0, 0, 1'b0, 54, 4'h0};
    tbl[2] = '{4'h8, -1, -1, -1, 0, -1, 1'b0, 0, 1'b0, 13, 4'h0};
    tbl[3] = '{4'h2, -1, 4095, -1, -1, -1, 1'b0, 0, 1'b0, 4108, 4'h0};
    tbl[4] = '{4'h0, -1, -1, -1, -1, -1, 1'b1, 1, 1'b0, 12, 4'h0};
    tbl[5] = '{4'h3, 5, 7, -1, -1, -1, 1'b0, 2, 1'b1, 26, 4'h0};
    tbl[6] = '{4'hf, 3, 3, -1, 3, -1, 1'b0, 3, 1'b0, 4120, 4'h4};

    rst_i = 1'b1;
    trig_i = 1'b0;
    rd_ack_i = 1'b0;
    lab_enable_i = '0;
    done_i = '0;
    for (int i = 0; i < N; i++) lab_lat[i] = -1;
    exp_occ = 0; exp_wr = 0; exp_rd = 0; exp_drop = 0; exp_to_acc = '0;
    repeat (3) @(posedge clk_i);
    #1 check_zero("reset");
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 check("idle_after_reset", hold_o, 0);

    for (int v = 0; v < 7; v++) begin
      lab_lat[0] = tbl[v].lat0;
      lab_lat[1] = tbl[v].lat1;
      lab_lat[2] = tbl[v].lat2;
      lab_lat[3] = tbl[v].lat3;
      if (tbl[v].pre_drop) do_drop();
      for (int a = 0; a < tbl[v].pre_acks; a++) do_ack();
      run_event(tbl[v].mask, tbl[v].exp_fin, tbl[v].exp_to, tbl[v].stray, tbl[v].ack_fin,
                1'b0);
    end

    timeouts_left = 2;
    for (int e = 0; e < 30; e++) begin
      for (int i = 0; i < N; i++) begin
        lab_lat[i] = $urandom_range(0, 30);
        if (timeouts_left > 0 && $urandom_range(0, 31) == 0) begin
          lab_lat[i] = -1;
          timeouts_left--;
        end
      end
      m = 4'($urandom);
      stray = -1;
      if (m[0] && lab_lat[0] >= 3 && $urandom_range(0, 1) == 1) stray = $urandom_range(1, 3);
      for (int a = $urandom_range(0, 2); a > 0; a--) do_ack();
      if (exp_occ == 4) begin
        if ($urandom_range(0, 1) == 1) do_drop();
        do_ack();
      end
      make_plan(m);
      run_event(m, plan_fin, plan_to, stray, 1'($urandom_range(0, 1)), 1'b1);
    end

    for (int i = 0; i < N; i++) lab_lat[i] = -1;
    while (exp_occ < 4) run_event(4'h0, HD + N, 4'h0, -1, 1'b0, 1'b0);
    for (int k = 0; k < 258; k++) do_drop();
    check("drop_saturated", dropped_cnt_o, 255);
    while (exp_occ > 0) do_ack();
    do_ack();

    // Reset while LAB1 is being read.
    lab_lat[0] = 30; lab_lat[1] = -1; lab_lat[2] = 5; lab_lat[3] = 5;
    trig_i       = 1'b1;
    lab_enable_i = 4'hf;
    @(posedge clk_i);
    #1 trig_i = 1'b0;
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      @(posedge clk_i);
      #1 if (readout_o[1]) found = 1;
    end
    check("reset_wait_lab1", found, 1);
    repeat (3) @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1 check_zero("midreset");
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    exp_occ = 0; exp_wr = 0; exp_rd = 0; exp_drop = 0; exp_to_acc = '0;
    @(posedge clk_i);
    #1 check_zero("postreset");
    for (int i = 0; i < N; i++) lab_lat[i] = 20;
    run_event(4'hf, 96, 4'h0, -1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
